// File: rtl/tag_lookup_ctrl_if.sv
// ---------------------------------------------------------------------------
// tag_lookup_ctrl_if
// Handshake bundle between the lookup requester / refill unit and the
// tag-side controller.
//   req_valid/req_ready/req_index/req_tag : lookup request channel
//   resp_valid/resp_hit/resp_way          : one-cycle lookup result
//   miss_valid/miss_ready/miss_index/
//   miss_tag/miss_way                     : refill request channel
//   refill_done                           : refill unit finished the line
// Modports: master = requester/refill side, slave = controller side.
// ---------------------------------------------------------------------------
interface tag_lookup_ctrl_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int TAG_WIDTH  = 21
);
    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_index;
    logic [TAG_WIDTH-1:0]  req_tag;

    logic                  resp_valid;
    logic                  resp_hit;
    logic                  resp_way;

    logic                  miss_valid;
    logic                  miss_ready;
    logic [ADDR_WIDTH-1:0] miss_index;
    logic [TAG_WIDTH-1:0]  miss_tag;
    logic                  miss_way;

    logic                  refill_done;

    modport master (
        output req_valid, req_index, req_tag, miss_ready, refill_done,
        input  req_ready, resp_valid, resp_hit, resp_way,
               miss_valid, miss_index, miss_tag, miss_way
    );

    modport slave (
        input  req_valid, req_index, req_tag, miss_ready, refill_done,
        output req_ready, resp_valid, resp_hit, resp_way,
               miss_valid, miss_index, miss_tag, miss_way
    );
endinterface

// File: rtl/tag_lookup_ctrl.sv
// ---------------------------------------------------------------------------
// tag_lookup_ctrl
// Tag-side controller for a 2-way tag RAM. After reset it holds the tag RAM
// in self-clear for 2**ADDR_WIDTH cycles, then accepts lookups, compares both
// ways, reports hit/miss, selects a victim (invalid way first, then LRU),
// hands misses to the refill unit and writes the new tag / LRU state back.
//
// Tag word: [TW-1:0] way0 tag, [TW] way0 valid, [2TW:TW+1] way1 tag,
//           [2TW+1] way1 valid, [2TW+2] LRU (next victim).
//
// Ports
//   clk, resetn      : clock, asynchronous active-low reset
//   bus (slave)      : request / response / miss / refill handshakes
//   init_done        : invalidate sweep finished (held until reset)
//   tr_raddr, tr_re  : tag RAM read port (data returns next cycle on tr_dout)
//   tr_waddr, tr_we  : tag RAM write address / per-way write enable
//   tr_din           : tag RAM write word
//   tr_refill        : way-tag array write strobe (refill write)
//   tr_load_over     : steer RAM address to tr_waddr for LRU/valid update
//   tr_cache_reset   : active-low sweep control, 0 = tag RAM self-clears
//   perf_hits/misses : lookup counters, present only with TAG_LOOKUP_PERF_EN
//
// Build option: define TAG_LOOKUP_PERF_EN to add saturating hit/miss counters.
// ---------------------------------------------------------------------------
module tag_lookup_ctrl #(
    parameter int ADDR_WIDTH = 7,
    parameter int TAG_WIDTH  = 21
) (
    input  logic                     clk,
    input  logic                     resetn,
    tag_lookup_ctrl_if.slave         bus,
    output logic                     init_done,
    output logic [ADDR_WIDTH-1:0]    tr_raddr,
    output logic                     tr_re,
    output logic [ADDR_WIDTH-1:0]    tr_waddr,
    output logic [1:0]               tr_we,
    output logic [2*TAG_WIDTH+2:0]   tr_din,
    output logic                     tr_refill,
    output logic                     tr_load_over,
    output logic                     tr_cache_reset,
    input  logic [2*TAG_WIDTH+2:0]   tr_dout
`ifdef TAG_LOOKUP_PERF_EN
    ,
    output logic [31:0]              perf_hits,
    output logic [31:0]              perf_misses
`endif
);

    localparam int WORD_W = 2*TAG_WIDTH + 3;

    typedef enum logic [2:0] {
        S_INIT, S_IDLE, S_LOOKUP, S_UPDATE, S_MISS, S_WAIT, S_WRITE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  init_done_q, init_done_d;

    // Request context; only consumed in states that follow its capture,
    // so it needs no reset.
    logic [ADDR_WIDTH-1:0] index_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic [WORD_W-1:0]     word_q;
    logic                  way_q;

    logic                  accept;
    logic [TAG_WIDTH-1:0]  rd_tag0, rd_tag1;
    logic                  rd_val0, rd_val1, rd_lru;
    logic                  hit0, hit1, hit, victim, sel_way;

    // Install tag in the chosen way, mark it valid and point LRU at the
    // other way. The untouched way is carried over from the lookup read.
    function automatic logic [WORD_W-1:0] merge_way(
        input logic [WORD_W-1:0]    word,
        input logic                 way,
        input logic [TAG_WIDTH-1:0] tag
    );
        logic [WORD_W-1:0] r;
        r = word;
        if (!way) begin
            r[TAG_WIDTH-1:0] = tag;
            r[TAG_WIDTH]     = 1'b1;
        end else begin
            r[2*TAG_WIDTH:TAG_WIDTH+1] = tag;
            r[2*TAG_WIDTH+1]           = 1'b1;
        end
        r[WORD_W-1] = ~way;
        return r;
    endfunction

    assign accept = (state_q == S_IDLE) && bus.req_valid;

    // Way compare on the word returned for the accepted request.
    always_comb begin
        rd_tag0 = tr_dout[TAG_WIDTH-1:0];
        rd_val0 = tr_dout[TAG_WIDTH];
        rd_tag1 = tr_dout[2*TAG_WIDTH:TAG_WIDTH+1];
        rd_val1 = tr_dout[2*TAG_WIDTH+1];
        rd_lru  = tr_dout[WORD_W-1];
        hit0    = rd_val0 && (rd_tag0 == tag_q);
        hit1    = rd_val1 && (rd_tag1 == tag_q);
        hit     = hit0 || hit1;
        victim  = !rd_val0 ? 1'b0 : (!rd_val1 ? 1'b1 : rd_lru);
        // A double hit is illegal; way0 wins.
        sel_way = hit0 ? 1'b0 : (hit1 ? 1'b1 : victim);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            index_q <= bus.req_index;
            tag_q   <= bus.req_tag;
        end
        if (state_q == S_LOOKUP) begin
            word_q <= tr_dout;
            way_q  <= sel_way;
        end
    end

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        init_done_d    = init_done_q;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_hit   = 1'b0;
        bus.resp_way   = 1'b0;
        bus.miss_valid = 1'b0;
        bus.miss_index = '0;
        bus.miss_tag   = '0;
        bus.miss_way   = 1'b0;
        tr_raddr       = '0;
        tr_re          = 1'b0;
        tr_waddr       = '0;
        tr_we          = 2'b00;
        tr_din         = '0;
        tr_refill      = 1'b0;
        tr_load_over   = 1'b0;

        case (state_q)
            S_INIT: begin
                // Counter wraps naturally on the last set, no extra cycle.
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                    init_done_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    tr_re    = 1'b1;
                    tr_raddr = bus.req_index;
                    state_d  = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                bus.resp_valid = 1'b1;
                bus.resp_hit   = hit;
                bus.resp_way   = sel_way;
                state_d        = hit ? S_UPDATE : S_MISS;
            end
            S_UPDATE: begin
                tr_load_over = 1'b1;
                tr_waddr     = index_q;
                tr_we        = way_q ? 2'b10 : 2'b01;
                tr_din       = merge_way(word_q, way_q, tag_q);
                state_d      = S_IDLE;
            end
            S_MISS: begin
                bus.miss_valid = 1'b1;
                bus.miss_index = index_q;
                bus.miss_tag   = tag_q;
                bus.miss_way   = way_q;
                if (bus.miss_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.refill_done) begin
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                tr_refill = 1'b1;
                tr_waddr  = index_q;
                tr_we     = way_q ? 2'b10 : 2'b01;
                tr_din    = merge_way(word_q, way_q, tag_q);
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    assign init_done      = init_done_q;
    assign tr_cache_reset = init_done_q;

`ifdef TAG_LOOKUP_PERF_EN
    logic [31:0] perf_hits_q, perf_misses_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_hits_q   <= '0;
            perf_misses_q <= '0;
        end else if (bus.resp_valid) begin
            if (bus.resp_hit && (perf_hits_q != 32'hFFFF_FFFF)) begin
                perf_hits_q <= perf_hits_q + 32'd1;
            end
            if (!bus.resp_hit && (perf_misses_q != 32'hFFFF_FFFF)) begin
                perf_misses_q <= perf_misses_q + 32'd1;
            end
        end
    end

    assign perf_hits   = perf_hits_q;
    assign perf_misses = perf_misses_q;
`endif

endmodule

// File: tb/tb_tag_lookup_ctrl.sv
module tb_tag_lookup_ctrl;
    localparam int AW    = 7;
    localparam int TW    = 21;
    localparam int WW    = 2*TW + 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          resetn;
    logic          init_done;
    logic [AW-1:0] tr_raddr, tr_waddr;
    logic          tr_re, tr_refill, tr_load_over, tr_cache_reset;
    logic [1:0]    tr_we;
    logic [WW-1:0] tr_din;
    logic [WW-1:0] tr_dout;
`ifdef TAG_LOOKUP_PERF_EN
    logic [31:0]   perf_hits, perf_misses;
`endif

    tag_lookup_ctrl_if #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus ();

    tag_lookup_ctrl #(.ADDR_WIDTH(AW), .TAG_WIDTH(TW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .bus            (bus),
        .init_done      (init_done),
        .tr_raddr       (tr_raddr),
        .tr_re          (tr_re),
        .tr_waddr       (tr_waddr),
        .tr_we          (tr_we),
        .tr_din         (tr_din),
        .tr_refill      (tr_refill),
        .tr_load_over   (tr_load_over),
        .tr_cache_reset (tr_cache_reset),
        .tr_dout        (tr_dout)
`ifdef TAG_LOOKUP_PERF_EN
        ,
        .perf_hits      (perf_hits),
        .perf_misses    (perf_misses)
`endif
    );

    always #5 clk = ~clk;

    // Tag RAM behavioural model: self-clear while tr_cache_reset is low,
    // per-way writes (LRU written with any way), registered read.
    logic [WW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (!tr_cache_reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (tr_we != 2'b00) begin
            if (tr_we[0]) mem[tr_waddr][TW:0]      <= tr_din[TW:0];
            if (tr_we[1]) mem[tr_waddr][2*TW+1:TW+1] <= tr_din[2*TW+1:TW+1];
            mem[tr_waddr][WW-1] <= tr_din[WW-1];
        end
        if (tr_re) tr_dout <= mem[tr_raddr];
    end

    // Reference cache state
    logic [TW-1:0] m_tag [DEPTH][2];
    logic          m_val [DEPTH][2];
    logic          m_lru [DEPTH];

    typedef struct packed { logic hit; logic way; } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int exp_hits = 0;
    int exp_misses = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            m_val[i][0] = 1'b0; m_val[i][1] = 1'b0;
            m_tag[i][0] = '0;   m_tag[i][1] = '0;
            m_lru[i]    = 1'b0;
        end
        exp_hits   = 0;
        exp_misses = 0;
        exp_q.delete();
    endtask

    function automatic logic [WW-1:0] model_word(input int idx);
        return {m_lru[idx], m_val[idx][1], m_tag[idx][1], m_val[idx][0], m_tag[idx][0]};
    endfunction

    task automatic model_install(input int idx, input logic [TW-1:0] tg, input logic way);
        m_tag[idx][way] = tg;
        m_val[idx][way] = 1'b1;
        m_lru[idx]      = ~way;
    endtask

    // Releases reset and measures the sweep; optional req_valid held early.
    task automatic run_init(input bit poke_req);
        int cycles, low, rdy_seen;
        cycles = 0; low = 0; rdy_seen = 0;
        @(negedge clk);
        resetn = 1'b1;
        bus.req_valid = poke_req;
        bus.req_index = 7'd3;
        bus.req_tag   = 21'h55;
        while (!init_done && cycles < 300) begin
            if (!tr_cache_reset) low++;
            if (bus.req_ready || tr_re) rdy_seen++;
            @(posedge clk); #1;
            cycles++;
            if (cycles == 100) bus.req_valid = 1'b0;
        end
        chk("init_cycles", cycles, DEPTH);
        chk("init_cache_reset_low", low, DEPTH);
        chk("init_no_accept", rdy_seen, 0);
        chk("init_done", init_done, 1);
        chk("cache_reset_high", tr_cache_reset, 1);
        chk("ready_after_init", bus.req_ready, 1);
    endtask

    // One lookup. rdy_delay: cycles miss_valid is held before miss_ready.
    // abort: stop in WAIT without finishing the refill.
    task automatic do_lookup(input int idx, input logic [TW-1:0] tg,
                             input int rdy_delay, input bit abort);
        exp_t e, got;
        logic h0, h1, way;
        int n;
        h0 = m_val[idx][0] && (m_tag[idx][0] == tg);
        h1 = m_val[idx][1] && (m_tag[idx][1] == tg);
        e.hit = h0 | h1;
        way   = h0 ? 1'b0 : h1 ? 1'b1 : !m_val[idx][0] ? 1'b0 : !m_val[idx][1] ? 1'b1 : m_lru[idx];
        e.way = way;
        exp_q.push_back(e);

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_index = idx[AW-1:0];
        bus.req_tag   = tg;
        #1;
        chk("req_ready", bus.req_ready, 1);
        chk("tr_re", tr_re, 1);
        chk("tr_raddr", tr_raddr, idx);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("busy_not_ready", bus.req_ready, 0);
        n = 0;
        while (!bus.resp_valid && n < 4) begin
            @(posedge clk); #1; n++;
        end
        chk("resp_latency", n, 0);
        if (!bus.resp_valid) return;
        got.hit = bus.resp_hit;
        got.way = bus.resp_way;
        e = exp_q.pop_front();
        chk("resp_hit", got.hit, e.hit);
        chk("resp_way", got.way, e.way);
        if (e.hit) exp_hits++; else exp_misses++;

        if (e.hit) begin
            model_install(idx, tg, e.way);
            @(posedge clk); #1;
            chk("upd_load_over", tr_load_over, 1);
            chk("upd_we", tr_we, e.way ? 2'b10 : 2'b01);
            chk("upd_waddr", tr_waddr, idx);
            chk("upd_din", tr_din, model_word(idx));
            chk("upd_no_re_refill", {tr_re, tr_refill}, 2'b00);
        end else begin
            bus.miss_ready = (rdy_delay == 0);
            @(posedge clk); #1;
            chk("miss_valid", bus.miss_valid, 1);
            chk("miss_index", bus.miss_index, idx);
            chk("miss_tag", bus.miss_tag, tg);
            chk("miss_way", bus.miss_way, e.way);
            for (int k = 0; k < rdy_delay; k++) begin
                @(posedge clk); #1;
                chk("miss_hold", {bus.miss_valid, bus.miss_tag, bus.miss_way}, {1'b1, tg, e.way});
            end
            bus.miss_ready = 1'b1;
            @(posedge clk); #1;
            bus.miss_ready = 1'b0;
            chk("wait_miss_dropped", bus.miss_valid, 0);
            if (abort) return;
            @(posedge clk); #1;
            chk("wait_no_write", tr_we, 2'b00);
            bus.refill_done = 1'b1;
            @(posedge clk); #1;
            bus.refill_done = 1'b0;
            model_install(idx, tg, e.way);
            chk("wr_refill", tr_refill, 1);
            chk("wr_we", tr_we, e.way ? 2'b10 : 2'b01);
            chk("wr_waddr", tr_waddr, idx);
            chk("wr_din", tr_din, model_word(idx));
            chk("wr_no_re_load", {tr_re, tr_load_over}, 2'b00);
        end
        @(posedge clk); #1;
        chk("back_idle", bus.req_ready, 1);
    endtask

    initial begin
        resetn          = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_index   = '0;
        bus.req_tag     = '0;
        bus.miss_ready  = 1'b0;
        bus.refill_done = 1'b0;
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_init_done", init_done, 0);
        chk("rst_cache_reset", tr_cache_reset, 0);
        chk("rst_outputs", {bus.req_ready, bus.resp_valid, bus.miss_valid, tr_re, tr_we,
                            tr_refill, tr_load_over}, 0);

        run_init(1'b1);

        // refill_done in IDLE must be ignored
        @(negedge clk);
        bus.refill_done = 1'b1;
        @(posedge clk); #1;
        bus.refill_done = 1'b0;
        chk("idle_refill_ignored", {tr_refill, tr_we, bus.req_ready}, {1'b0, 2'b00, 1'b1});

        do_lookup(5, 21'h1234, 0, 1'b0);     // cold miss, way0, ready same cycle
        chk("cold_lru", mem[5][WW-1], 1);
        do_lookup(5, 21'h1234, 0, 1'b0);     // hit way0
        do_lookup(5, 21'h5678, 2, 1'b0);     // miss into invalid way1
        do_lookup(5, 21'h9999, 1, 1'b0);     // both valid, LRU=0 -> way0
        do_lookup(5, 21'h5678, 0, 1'b0);     // hit way1
        do_lookup(127, 21'h1FFFFF, 0, 1'b0); // top index
        do_lookup(127, 21'h1FFFFF, 0, 1'b0);
        do_lookup(0, 21'h0ABCDE, 3, 1'b0);

`ifdef TAG_LOOKUP_PERF_EN
        chk("perf_hits", perf_hits, exp_hits);
        chk("perf_misses", perf_misses, exp_misses);
`endif

        // Reset while waiting for the refill
        do_lookup(9, 21'h777, 1, 1'b1);
        resetn = 1'b0;
        #1;
        chk("abort_miss_valid", bus.miss_valid, 0);
        chk("abort_init_done", init_done, 0);
        chk("abort_cache_reset", tr_cache_reset, 0);
        clear_model();
        bus.refill_done = 1'b1;
        @(posedge clk); #1;
        bus.refill_done = 1'b0;
        chk("abort_refill_ignored", {tr_refill, tr_we}, 3'b000);
`ifdef TAG_LOOKUP_PERF_EN
        chk("perf_cleared", {perf_hits, perf_misses}, 64'd0);
`endif
        run_init(1'b0);
        do_lookup(9, 21'h777, 0, 1'b0);      // sweep wiped the set
        do_lookup(5, 21'h1234, 0, 1'b0);
        do_lookup(5, 21'h1234, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
